// File: rtl/fetch_if.sv
// IF-stage control bundle: hazard/EX inputs, imem request channel and IF outputs.
// master = fetch controller, slave = the pipeline/imem side driving it.
interface fetch_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] pred_addr;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        misalign;

    modport master (
        input  stall, redirect_valid, redirect_addr, pred_addr, imem_ready,
        output imem_req, imem_addr, if_pc, if_valid, misalign
    );

    modport slave (
        output stall, redirect_valid, redirect_addr, pred_addr, imem_ready,
        input  imem_req, imem_addr, if_pc, if_valid, misalign
    );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, selects the next fetch address and absorbs imem wait states.
// Optional MISALIGN_TRAP_EN: misaligned targets fetch TRAP_PC and flag the trap instruction.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input logic    clk,
    input logic    rst_n,
    fetch_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic        vld_q;
    logic [31:0] sel;
    logic [31:0] raw_addr;
    logic [31:0] fetch_addr;
    logic        accept;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel      = bus.pred_addr;
        raw_addr = RESET_PC;
        if (bus.redirect_valid) sel = bus.redirect_addr;
        else if (bus.stall)     sel = pc_q;
        case (state)
            BOOT:    raw_addr = RESET_PC;
            RUN:     raw_addr = sel;
            WAIT:    raw_addr = bus.redirect_valid ? bus.redirect_addr : pend_q;
            default: raw_addr = RESET_PC;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    logic trap;

    assign trap       = (state != BOOT) && (raw_addr[1:0] != 2'b00);
    assign fetch_addr = trap ? TRAP_PC : raw_addr;
    assign bus.misalign = mis_q & bus.if_valid;
`else
    assign fetch_addr   = raw_addr & ~32'h3;
    assign bus.misalign = 1'b0;
`endif

    // Request is raised in every state; only reset suppresses it.
    assign bus.imem_req  = rst_n;
    assign bus.imem_addr = fetch_addr;
    assign accept        = bus.imem_req & bus.imem_ready;
    assign bus.if_pc     = rst_n ? pc_q : RESET_PC;
    assign bus.if_valid  = rst_n & vld_q & (state == RUN) & ~bus.redirect_valid;

    // NOTE: reset is synchronous, so it lives inside the clocked block rather than its sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= BOOT;
            pc_q   <= RESET_PC;
            pend_q <= RESET_PC;
            vld_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                pc_q  <= fetch_addr;
                vld_q <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                mis_q <= trap;
`endif
            end
            case (state)
                BOOT: if (accept) state <= RUN;
                RUN: begin
                    if (!accept) begin
                        state  <= WAIT;
                        pend_q <= sel;
                        vld_q  <= 1'b0;
                    end
                end
                WAIT: begin
                    // A redirect during the wait makes the older pending fetch wrong-path.
                    if (accept)                  state  <= RUN;
                    else if (bus.redirect_valid) pend_q <= bus.redirect_addr;
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; inputs change and outputs are sampled around the falling edge.
// The jump generator is modelled as if_pc+4 unless a directed target overrides it.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        pred_ovr_en;
    logic [31:0] pred_ovr;

    fetch_if bus ();

    fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.pred_addr = pred_ovr_en ? pred_ovr : bus.if_pc + 32'd4;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance to the next falling edge; callers then set inputs and wait #1 before sampling.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr = 32'h0;
        bus.imem_ready = 1'b1;
        pred_ovr_en = 1'b0;
        pred_ovr = 32'h0;

        // Reset state
        next_cycle(); #1;
        check("rst_req",   {31'b0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_pc",    bus.if_pc, 32'h2000);
        check("rst_mis",   {31'b0, bus.misalign}, 32'd0);

        // Boot fetch of RESET_PC
        next_cycle(); rst_n = 1'b1; #1;
        check("boot_req",   {31'b0, bus.imem_req}, 32'd1);
        check("boot_addr",  bus.imem_addr, 32'h2000);
        check("boot_valid", {31'b0, bus.if_valid}, 32'd0);

        // Sequential stream
        next_cycle(); #1;
        check("seq0_pc",    bus.if_pc, 32'h2000);
        check("seq0_valid", {31'b0, bus.if_valid}, 32'd1);
        check("seq0_addr",  bus.imem_addr, 32'h2004);
        next_cycle(); #1;
        check("seq1_pc",    bus.if_pc, 32'h2004);

        // Stall three cycles at 0x2004
        bus.stall = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_addr",  bus.imem_addr, 32'h2004);
            check("stall_pc",    bus.if_pc, 32'h2004);
            check("stall_valid", {31'b0, bus.if_valid}, 32'd1);
            next_cycle();
            if (i == 2) bus.stall = 1'b0;
            #1;
        end
        check("unstall_pc",   bus.if_pc, 32'h2004);
        check("unstall_addr", bus.imem_addr, 32'h2008);
        next_cycle(); #1;
        check("seq2_pc", bus.if_pc, 32'h2008);

        // JAL target from the jump generator
        pred_ovr_en = 1'b1; pred_ovr = 32'h2100; #1;
        check("jal_addr", bus.imem_addr, 32'h2100);
        next_cycle(); pred_ovr_en = 1'b0; #1;
        check("jal_pc",    bus.if_pc, 32'h2100);
        check("jal_valid", {31'b0, bus.if_valid}, 32'd1);
        check("jal_next",  bus.imem_addr, 32'h2104);

        // Redirect together with stall: redirect wins
        bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h3000; bus.stall = 1'b1; #1;
        check("rdst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rdst_addr",  bus.imem_addr, 32'h3000);
        next_cycle(); bus.redirect_valid = 1'b0; bus.stall = 1'b0; #1;
        check("rdst_pc",     bus.if_pc, 32'h3000);
        check("rdst_valid1", {31'b0, bus.if_valid}, 32'd1);

        // Wait states with a redirect during WAIT
        bus.imem_ready = 1'b0; #1;
        check("w0_valid", {31'b0, bus.if_valid}, 32'd1);
        check("w0_addr",  bus.imem_addr, 32'h3004);
        next_cycle(); #1;
        check("w1_valid", {31'b0, bus.if_valid}, 32'd0);
        check("w1_addr",  bus.imem_addr, 32'h3004);
        bus.stall = 1'b1; #1;
        check("w1_stall_ignored", bus.imem_addr, 32'h3004);
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h4000; #1;
        check("w1_rd_addr", bus.imem_addr, 32'h4000);
        next_cycle(); bus.redirect_valid = 1'b0; bus.imem_ready = 1'b1; #1;
        check("w2_addr",  bus.imem_addr, 32'h4000);
        check("w2_valid", {31'b0, bus.if_valid}, 32'd0);
        next_cycle(); #1;
        check("w3_pc",    bus.if_pc, 32'h4000);
        check("w3_valid", {31'b0, bus.if_valid}, 32'd1);

        // Back-to-back redirects: last target wins
        bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h5000; #1;
        check("b2b0_valid", {31'b0, bus.if_valid}, 32'd0);
        next_cycle(); bus.redirect_addr = 32'h6000; #1;
        check("b2b1_pc",    bus.if_pc, 32'h5000);
        check("b2b1_valid", {31'b0, bus.if_valid}, 32'd0);
        next_cycle(); bus.redirect_valid = 1'b0; #1;
        check("b2b2_pc",    bus.if_pc, 32'h6000);
        check("b2b2_valid", {31'b0, bus.if_valid}, 32'd1);

        // Reset in the middle of WAIT
        bus.imem_ready = 1'b0; #1;
        next_cycle(); #1;
        check("mw_addr", bus.imem_addr, 32'h6004);
        rst_n = 1'b0; #1;
        check("mw_rst_req",   {31'b0, bus.imem_req}, 32'd0);
        check("mw_rst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("mw_rst_pc",    bus.if_pc, 32'h2000);
        next_cycle(); rst_n = 1'b1; bus.imem_ready = 1'b1; #1;
        check("mw_boot_addr",  bus.imem_addr, 32'h2000);
        check("mw_boot_valid", {31'b0, bus.if_valid}, 32'd0);
        next_cycle(); #1;
        check("mw_run_pc",    bus.if_pc, 32'h2000);
        check("mw_run_valid", {31'b0, bus.if_valid}, 32'd1);

        // Misaligned redirect target
        bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h3002; #1;
`ifdef MISALIGN_TRAP_EN
        check("mis_addr", bus.imem_addr, 32'h0100);
        next_cycle(); bus.redirect_valid = 1'b0; #1;
        check("mis_pc",   bus.if_pc, 32'h0100);
        check("mis_flag", {31'b0, bus.misalign}, 32'd1);
`else
        check("mis_addr", bus.imem_addr, 32'h3000);
        next_cycle(); bus.redirect_valid = 1'b0; #1;
        check("mis_pc",   bus.if_pc, 32'h3000);
        check("mis_flag", {31'b0, bus.misalign}, 32'd0);
`endif
        check("mis_valid", {31'b0, bus.if_valid}, 32'd1);
        next_cycle(); #1;
        check("mis_clear", {31'b0, bus.misalign}, 32'd0);

        // 32-bit wrap comes from the producer unchanged
        pred_ovr_en = 1'b1; pred_ovr = 32'hFFFF_FFFC; #1;
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        next_cycle(); pred_ovr_en = 1'b0; #1;
        check("wrap_pc",   bus.if_pc, 32'hFFFF_FFFC);
        check("wrap_next", bus.imem_addr, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
